// File: rtl/fifo_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// fifo_tx_sequencer_if
// Bundle of the handshake and data signals between the transmit-FIFO drain
// sequencer, the UART transmit FIFO and the UART transmitter.
//
// Signals (names are from the sequencer's point of view):
//   iEnable        stream enable from the rest of the design
//   iFifoEmpty     FIFO empty flag
//   oFifoReadEn    single-cycle pop strobe to the FIFO
//   iFifoReadData  FIFO read data, valid the cycle after the pop
//   iTxBusy        transmitter busy (registered in the transmitter)
//   oTxStart       single-cycle start strobe to the transmitter
//   oTxData        byte handed to the transmitter
//   oBusy          sequencer is working on a byte
//   oByteCount     bytes started since reset, wrapping
//
// Modports:
//   master  the sequencer itself
//   slave   the FIFO/transmitter/controller side
// ---------------------------------------------------------------------------
interface fifo_tx_sequencer_if #(
  parameter int pFifoDataWidth = 8,
  parameter int pCountWidth    = 16
);
  logic                      iEnable;
  logic                      iFifoEmpty;
  logic                      oFifoReadEn;
  logic [pFifoDataWidth-1:0] iFifoReadData;
  logic                      iTxBusy;
  logic                      oTxStart;
  logic [pFifoDataWidth-1:0] oTxData;
  logic                      oBusy;
  logic [pCountWidth-1:0]    oByteCount;

  modport master (
    input  iEnable, iFifoEmpty, iFifoReadData, iTxBusy,
    output oFifoReadEn, oTxStart, oTxData, oBusy, oByteCount
  );

  modport slave (
    output iEnable, iFifoEmpty, iFifoReadData, iTxBusy,
    input  oFifoReadEn, oTxStart, oTxData, oBusy, oByteCount
  );
endinterface

// File: rtl/fifo_tx_sequencer.sv
// ---------------------------------------------------------------------------
// fifo_tx_sequencer
// Drains the UART transmit FIFO into the UART transmitter one byte at a time.
// Pops a byte, waits out the FIFO's registered read latency, launches the
// byte with a one-cycle start pulse, waits for the transmitter to go idle and
// then holds off for a programmable number of gap cycles.
//
// Parameters:
//   pFifoDataWidth  byte width of FIFO and transmitter data
//   pGapCycles      idle clocks after each byte (0 = no gap)
//   pCountWidth     width of the sent-byte counter
//
// Ports:
//   iClk  system clock, rising edge
//   iRst  asynchronous active-high reset
//   bus   fifo_tx_sequencer_if.master (FIFO, transmitter and status signals)
// ---------------------------------------------------------------------------
module fifo_tx_sequencer #(
  parameter int pFifoDataWidth = 8,
  parameter int pGapCycles     = 2,
  parameter int pCountWidth    = 16
) (
  input logic                  iClk,
  input logic                  iRst,
  fifo_tx_sequencer_if.master  bus
);

  // Gap counter only has to hold pGapCycles; keep at least one bit so the
  // no-gap build still elaborates cleanly.
  localparam int lpGapWidth = (pGapCycles < 2) ? 1 : $clog2(pGapCycles + 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    START,
    WAIT_TX,
    GAP
  } tState;

  tState                     r_state;
  tState                     w_nextState;
  logic [pFifoDataWidth-1:0] r_txData;
  logic [pCountWidth-1:0]    r_byteCount;
  logic [lpGapWidth-1:0]     r_gapCount;
  logic                      r_guardDone;
  logic                      w_fifoReadEn;
  logic                      w_txStart;
  logic                      w_busy;

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and state-decoded outputs. Enable, empty and busy only matter
  // in IDLE, so a byte that has been popped always runs to completion.
  // WAIT_TX ignores iTxBusy in its first cycle because the transmitter's busy
  // flag is registered and cannot yet reflect the start pulse.
  always_comb begin
    w_nextState  = r_state;
    w_fifoReadEn = 1'b0;
    w_txStart    = 1'b0;
    w_busy       = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (bus.iEnable && !bus.iFifoEmpty && !bus.iTxBusy) begin
          w_nextState = POP;
        end
      end
      POP: begin
        w_fifoReadEn = 1'b1;
        w_nextState  = CAPTURE;
      end
      CAPTURE: begin
        w_nextState = START;
      end
      START: begin
        w_txStart   = 1'b1;
        w_nextState = WAIT_TX;
      end
      WAIT_TX: begin
        if (r_guardDone && !bus.iTxBusy) begin
          w_nextState = (pGapCycles > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (r_gapCount == lpGapWidth'(1)) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: captured byte, wrapping byte counter, WAIT_TX guard flag and
  // gap down-counter (loaded on the way into GAP).
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_txData    <= '0;
      r_byteCount <= '0;
      r_gapCount  <= '0;
      r_guardDone <= 1'b0;
    end else begin
      if (r_state == CAPTURE) begin
        r_txData <= bus.iFifoReadData;
      end
      if (r_state == START) begin
        r_byteCount <= r_byteCount + pCountWidth'(1);
      end
      r_guardDone <= (r_state == WAIT_TX);
      if (r_state == WAIT_TX && w_nextState == GAP) begin
        r_gapCount <= lpGapWidth'(pGapCycles);
      end else if (r_state == GAP) begin
        r_gapCount <= r_gapCount - lpGapWidth'(1);
      end
    end
  end

  assign bus.oFifoReadEn = w_fifoReadEn;
  assign bus.oTxStart    = w_txStart;
  assign bus.oBusy       = w_busy;
  assign bus.oTxData     = r_txData;
  assign bus.oByteCount  = r_byteCount;

endmodule

// File: tb/tb_fifo_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fifo_tx_sequencer
// Self-checking bench for fifo_tx_sequencer. Instance A uses the default
// parameters (gap 2, 16-bit counter); instance B uses gap 0 and a 4-bit
// counter. A small FIFO/transmitter model responds to the selected instance.
// ---------------------------------------------------------------------------
module tb_fifo_tx_sequencer;

  typedef struct {
    logic       en;
    logic       empty;
    logic       busyIn;
    logic [7:0] data;
    logic       expRead;
    logic       expStart;
    logic       expBusy;
    logic [7:0] expData;
    logic [15:0] expCount;
  } tVector;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  logic enable;
  logic fifoEmpty;
  logic txBusy;
  logic [7:0] fifoData;

  fifo_tx_sequencer_if #(.pFifoDataWidth(8), .pCountWidth(16)) busA ();
  fifo_tx_sequencer_if #(.pFifoDataWidth(8), .pCountWidth(4))  busB ();

  assign busA.iEnable       = enable;
  assign busA.iFifoEmpty    = fifoEmpty;
  assign busA.iFifoReadData = fifoData;
  assign busA.iTxBusy       = txBusy;
  assign busB.iEnable       = enable;
  assign busB.iFifoEmpty    = fifoEmpty;
  assign busB.iFifoReadData = fifoData;
  assign busB.iTxBusy       = txBusy;

  fifo_tx_sequencer #(.pFifoDataWidth(8), .pGapCycles(2), .pCountWidth(16)) dutA (
    .iClk (clk),
    .iRst (rstA),
    .bus  (busA)
  );

  fifo_tx_sequencer #(.pFifoDataWidth(8), .pGapCycles(0), .pCountWidth(4)) dutB (
    .iClk (clk),
    .iRst (rstB),
    .bus  (busB)
  );

  always #5 clk = ~clk;

  // Outputs of whichever instance is under test.
  logic        sel;
  logic        sReadEn;
  logic        sTxStart;
  logic        sBusy;
  logic [7:0]  sTxData;
  logic [15:0] sCount;

  always_comb begin
    if (sel) begin
      sReadEn  = busB.oFifoReadEn;
      sTxStart = busB.oTxStart;
      sBusy    = busB.oBusy;
      sTxData  = busB.oTxData;
      sCount   = {12'd0, busB.oByteCount};
    end else begin
      sReadEn  = busA.oFifoReadEn;
      sTxStart = busA.oTxStart;
      sBusy    = busA.oBusy;
      sTxData  = busA.oTxData;
      sCount   = busA.oByteCount;
    end
  end

  int assertCount;
  int failCount;
  int cyc;
  int popCount;
  int startCount;
  int badPopCount;
  int busyLen;
  int busyRemain;
  logic busyHold;
  logic modelOn;
  logic [7:0] q[$];
  logic [7:0] expQ[$];
  tVector vecs[19];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input tVector v);
    enable    = v.en;
    fifoEmpty = v.empty;
    txBusy    = v.busyIn;
    fifoData  = v.data;
  endtask

  task automatic pushByte(input logic [7:0] b);
    q.push_back(b);
    expQ.push_back(b);
    fifoEmpty = 1'b0;
  endtask

  // One clock: account for the current cycle's strobes, advance, then let
  // the FIFO and transmitter models react to them.
  task automatic stepCycle();
    logic       wasRead;
    logic       wasStart;
    logic [7:0] exp;
    wasRead  = sReadEn;
    wasStart = sTxStart;
    if (modelOn) begin
      if (wasRead) begin
        popCount++;
        if (fifoEmpty) badPopCount++;
      end
      if (wasStart) begin
        startCount++;
        exp = 'x;
        if (expQ.size() > 0) exp = expQ.pop_front();
        checkOutput("tx data order", {24'd0, sTxData}, {24'd0, exp});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (modelOn) begin
      if (wasRead && q.size() > 0) fifoData = q.pop_front();
      fifoEmpty = (q.size() == 0);
      if (wasStart) busyRemain = busyLen;
      txBusy = busyHold || (busyRemain > 0);
      if (busyRemain > 0) busyRemain--;
    end
  endtask

  task automatic runUntilIdle(input int maxCycles, input string name);
    int n;
    n = 0;
    stepCycle();
    while ((sBusy || q.size() > 0 || txBusy) && n < maxCycles) begin
      stepCycle();
      n++;
    end
    checkOutput({name, " drained in budget"}, (n < maxCycles) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic applyReset(input logic useB);
    rstA = 1'b1;
    rstB = 1'b1;
    enable = 1'b0;
    fifoEmpty = 1'b1;
    txBusy = 1'b0;
    fifoData = 8'h00;
    busyHold = 1'b0;
    busyRemain = 0;
    q.delete();
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    sel = useB;
    if (useB) rstB = 1'b0;
    else rstA = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int k;
    int last;
    int popBase;
    int startBase;

    assertCount = 0; failCount = 0; cyc = 0;
    popCount = 0; startCount = 0; badPopCount = 0;
    busyLen = 0; busyRemain = 0; busyHold = 1'b0;
    modelOn = 1'b0; sel = 1'b0;
    rstA = 1'b1; rstB = 1'b1;
    enable = 1'b0; fifoEmpty = 1'b1; txBusy = 1'b0; fifoData = 8'h00;

    // Single-byte vector table: 0xA5, transmitter busy for 10 cycles, gap 2.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 16'd0};
    for (int i = 4; i <= 13; i++)
      vecs[i] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 16'd1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 16'd1};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 16'd1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 16'd1};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 16'd1};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 16'd1};

    // Values held in reset.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", sBusy, 0);
    checkOutput("reset count", sCount, 0);
    checkOutput("reset readEn", sReadEn, 0);
    rstA = 1'b0;

    // Asynchronous reset in the middle of WAIT_TX with five bytes sent.
    $display("[TB] reset during WAIT_TX");
    modelOn = 1'b1;
    busyLen = 3;
    for (int i = 0; i < 5; i++) pushByte(8'(8'h11 + i));
    enable = 1'b1;
    n = 0;
    while (startCount < 5 && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("pre-reset count", sCount, 5);
    checkOutput("pre-reset busy", sBusy, 1);
    checkOutput("pre-reset data", sTxData, 8'h15);
    #2 rstA = 1'b1;
    #1;
    checkOutput("async reset readEn", sReadEn, 0);
    checkOutput("async reset start", sTxStart, 0);
    checkOutput("async reset busy", sBusy, 0);
    checkOutput("async reset data", sTxData, 0);
    checkOutput("async reset count", sCount, 0);
    enable = 1'b0; busyRemain = 0; txBusy = 1'b0;
    @(posedge clk);
    #1;
    rstA = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("post-reset busy", sBusy, 0);
    checkOutput("post-reset count", sCount, 0);

    // Table-driven single byte.
    $display("[TB] single byte table");
    modelOn = 1'b0;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d readEn", i), sReadEn, vecs[i].expRead);
      checkOutput($sformatf("row%0d start", i), sTxStart, vecs[i].expStart);
      checkOutput($sformatf("row%0d busy", i), sBusy, vecs[i].expBusy);
      checkOutput($sformatf("row%0d data", i), sTxData, vecs[i].expData);
      checkOutput($sformatf("row%0d count", i), sCount, vecs[i].expCount);
      @(posedge clk);
      #1;
    end

    // Burst drain of 16 bytes.
    $display("[TB] burst drain");
    modelOn = 1'b1;
    applyReset(1'b0);
    popBase = popCount; startBase = startCount; badPopCount = 0;
    busyLen = 4;
    for (int i = 1; i <= 16; i++) pushByte(8'(i));
    enable = 1'b1;
    runUntilIdle(400, "burst");
    checkOutput("burst starts", startCount - startBase, 16);
    checkOutput("burst pops", popCount - popBase, 16);
    checkOutput("burst pops while empty", badPopCount, 0);
    checkOutput("burst count", sCount, 16);

    // Enable dropped in the cycle of the third start.
    $display("[TB] enable gating");
    popBase = popCount; startBase = startCount;
    busyLen = 2;
    for (int i = 0; i < 8; i++) pushByte(8'(8'h31 + i));
    enable = 1'b1;
    n = 0;
    while (!(sTxStart && startCount == startBase + 2) && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("gate third start reached", sTxStart, 1);
    enable = 1'b0;
    repeat (40) stepCycle();
    checkOutput("gate pops held", popCount - popBase, 3);
    checkOutput("gate starts held", startCount - startBase, 3);
    checkOutput("gate idle", sBusy, 0);
    enable = 1'b1;
    stepCycle();
    checkOutput("gate pop at N+1", sReadEn, 1);
    stepCycle();
    stepCycle();
    checkOutput("gate start at N+3", sTxStart, 1);
    checkOutput("gate fourth data", sTxData, 8'h34);
    runUntilIdle(200, "gate resume");
    checkOutput("gate total starts", startCount - startBase, 8);
    checkOutput("gate count", sCount, 24);

    // Transmitter owned elsewhere: busy already high in IDLE.
    $display("[TB] busy precedence");
    popBase = popCount; startBase = startCount;
    busyHold = 1'b1; txBusy = 1'b1;
    pushByte(8'h5A);
    repeat (5) stepCycle();
    checkOutput("busy hold no pop", popCount - popBase, 0);
    checkOutput("busy hold idle", sBusy, 0);
    busyHold = 1'b0; txBusy = 1'b0;
    stepCycle();
    checkOutput("busy release pop", sReadEn, 1);
    runUntilIdle(100, "busy release");
    checkOutput("busy release starts", startCount - startBase, 1);

    // Instance B: no gap, transmitter never busy, 4-bit counter wrap.
    $display("[TB] no-gap period and counter wrap");
    applyReset(1'b1);
    busyLen = 0;
    for (int i = 0; i < 17; i++) pushByte(8'(8'h40 + i));
    enable = 1'b1;
    n = 0; k = 0; last = 0;
    while (k < 17 && n < 400) begin
      if (sTxStart) begin
        k++;
        if (k > 1 && k <= 4) checkOutput($sformatf("period byte%0d", k), cyc - last, 6);
        last = cyc;
        stepCycle();
        if (k == 15) checkOutput("wrap after 15", sCount, 15);
        if (k == 16) checkOutput("wrap after 16", sCount, 0);
        if (k == 17) checkOutput("wrap after 17", sCount, 1);
      end else begin
        stepCycle();
      end
      n++;
    end
    checkOutput("wrap all starts", k, 17);
    runUntilIdle(50, "wrap drain");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fifo_tx_sequencer.md
# fifo_tx_sequencer

Drain controller between the UART transmit FIFO and the UART transmitter in the IceBreak test design. It pops one byte at a time from the FIFO and absorbs the FIFO's one-cycle registered read latency. It launches each byte into the transmitter with a single-cycle start pulse, waits for the transmitter to finish, then enforces a programmable inter-byte gap. A gated enable lets the rest of the DMM design pause the transmit stream without losing the byte currently in flight.

## Interface
- pFifoDataWidth, 8: byte width of the FIFO and transmitter data.
- pGapCycles, 2: idle clocks inserted after each byte completes; 0 means no gap.
- pCountWidth, 16: width of the sent-byte counter.

- iClk  in  1  system clock; all logic on the rising edge.
- iRst  in  1  reset, asynchronous and active-high.
- iEnable  in  1  high permits new pops; low stops new bytes; the byte in flight still completes.
- iFifoEmpty  in  1  FIFO empty flag.
- oFifoReadEn  out  1  single-cycle pop strobe to the FIFO.
- iFifoReadData  in  pFifoDataWidth  FIFO output; valid in the cycle after oFifoReadEn.
- iTxBusy  in  1  transmitter busy; registered, so it rises the cycle after oTxStart.
- oTxStart  out  1  single-cycle start strobe to the transmitter.
- oTxData  out  pFifoDataWidth  byte to transmit; stable from START until the next CAPTURE.
- oBusy  out  1  high whenever the state is not IDLE.
- oByteCount  out  pCountWidth  total bytes started since reset; wraps modulo 2^pCountWidth.

## Operation
- Moore FSM. All outputs are registered or decoded from state only; no input-to-output combinational path.
- States and transitions:
  - IDLE -> POP when iEnable && !iFifoEmpty && !iTxBusy.
  - POP (oFifoReadEn=1) -> CAPTURE.
  - CAPTURE: oTxData <= iFifoReadData -> START.
  - START (oTxStart=1; oByteCount increments) -> WAIT_TX.
  - WAIT_TX:
    - The first cycle is a guard cycle: iTxBusy is ignored there.
    - After the guard, if !iTxBusy -> GAP when pGapCycles>0, else -> IDLE.
  - GAP: the gap counter loads pGapCycles on entry and decrements each cycle; the FSM leaves for IDLE when the count reaches 1, so GAP lasts exactly pGapCycles cycles.
- iEnable is sampled only in IDLE. Deassertion in any other state does not abort the current byte.
- iFifoEmpty is sampled only in IDLE. Exactly one pop is issued per byte, and never while empty.
- Reset, asynchronous, any state:
  - State returns to IDLE.
  - oFifoReadEn, oTxStart and oBusy go to 0; oTxData goes to 0; oByteCount goes to 0; the gap counter goes to 0.
  - A byte popped but not yet started is discarded. This is defined behaviour, not an error.
- oByteCount at all-ones plus one start gives 0. No saturation and no flag.

## Timing
- Cycle N is the IDLE cycle in which the start conditions hold. Then:
  - oFifoReadEn is high in N+1.
  - Data is captured at the end of N+2.
  - oTxStart is high in N+3, with oTxData already valid in N+3.
- Start latency is 3 clocks from a qualifying IDLE cycle to oTxStart.
- Per-byte period: 3 (POP, CAPTURE, START) + 1 guard + T_busy + pGapCycles + 1 (IDLE).
  - T_busy counts the WAIT_TX cycles, after the guard, in which iTxBusy is high.
  - For back-to-back bytes the WAIT_TX exit cycle is also counted.
- oFifoReadEn and oTxStart are each high for exactly one cycle per byte and are never high in the same cycle.
- If iTxBusy is already high in IDLE (transmitter owned elsewhere), the sequencer waits in IDLE.
- If iTxBusy never rises after oTxStart, WAIT_TX exits at the first post-guard cycle. This tolerates transmitters faster than one cycle.
- Reset release: the first pop can occur no earlier than the second rising edge after iRst falls.

## Test plan
- Reset values: assert iRst mid-WAIT_TX, with oByteCount=5 -> all outputs 0 within the same cycle (asynchronous); after release, state is IDLE, oBusy=0, oByteCount=0.
- Single byte: FIFO holds 0xA5, iEnable=1, transmitter busy for 10 cycles -> oFifoReadEn pulses once; 2 cycles later oTxStart pulses with oTxData=0xA5; oBusy stays high through 2 gap cycles; oByteCount=1; no second pop.
- Burst drain: write 0x01..0x10 (16 bytes, FIFO full) -> oTxStart fires 16 times with data in order 0x01..0x10; oFifoReadEn pulses 16 times; none occurs while oFifoEmpty=1; oByteCount=16.
- Enable gating: deassert iEnable in the cycle of the 3rd oTxStart, with 8 bytes queued -> the 3rd byte completes and no further pop occurs; reassert -> bytes 4..8 follow, the first start exactly 3 cycles after the qualifying IDLE cycle.
- Busy precedence: hold iTxBusy=1 while the FIFO is non-empty in IDLE -> no pop; release -> pop on the next cycle. Also: transmitter never asserts busy with pGapCycles=0 -> per-byte period of 6 cycles.
- Counter wrap: pCountWidth=4, send 17 bytes -> oByteCount reads 15 after byte 15, 0 after byte 16, 1 after byte 17.
